mem_access_unit: RTL and testbench



---
 rtl/mem_access_unit.sv | 185 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front end for a word-wide data memory
// (combinational read, level-sensitive write).
//
// Accepts byte/half/word loads and stores through a valid/ready handshake.
// Sub-word stores use read-modify-write. Loads are sign- or zero-extended.
// All memory-side outputs come straight from registers.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   : misaligned half/word accesses are suppressed and flagged via err
//   undefined : low address bits below the access size are ignored
//
// Ports:
//   clk, reset        clock (rising edge), synchronous active-high reset
//   req_valid/ready   request handshake; ready is high only in IDLE
//   req_write         1 = store, 0 = load
//   req_addr          byte address
//   req_size          00 byte, 01 half, 10/11 word
//   req_unsigned      loads zero-extend when 1
//   req_wdata         store data, right-aligned
//   done              one-cycle completion pulse
//   rdata, err        load result and suppressed-access flag, valid with done
//   mem_addr          word index to memory
//   mem_wdata         write word to memory
//   mem_write         memory write strobe
//   mem_read          memory read strobe
//   mem_rdata         memory read word
module mem_access_unit #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned IDX_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [31:0]          req_addr,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [31:0]          req_wdata,
  output logic                 done,
  output logic [31:0]          rdata,
  output logic                 err,
  output logic [IDX_WIDTH-1:0] mem_addr,
  output logic [31:0]          mem_wdata,
  output logic                 mem_write,
  output logic                 mem_read,
  input  logic [31:0]          mem_rdata
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RD     = 3'd1;
  localparam logic [2:0] ST_RMW_RD = 3'd2;
  localparam logic [2:0] ST_WR     = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  logic [2:0]  state;
  logic [1:0]  lane;      // req_addr[1:0] of the accepted request
  logic [1:0]  size;
  logic        is_unsigned;
  logic [31:0] wdata;

  logic        accept;
  logic        range_err;
  logic        misalign;
  logic        bad;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_ext;
  logic [31:0] merged;

  always_comb begin
    accept    = req_valid & req_ready;
    range_err = {2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS);
`ifdef MISALIGN_TRAP_EN
    misalign  = ((req_size == 2'b01) && req_addr[0]) ||
                (req_size[1] && (req_addr[1:0] != 2'b00));
`else
    misalign  = 1'b0;
`endif
    bad       = range_err | misalign;
  end

  // Load lane extraction and extension, using the latched request fields.
  always_comb begin
    ld_byte  = 8'(mem_rdata >> {lane, 3'b000});
    ld_half  = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_ext = mem_rdata;
    case (size)
      2'b00:   load_ext = {{24{~is_unsigned & ld_byte[7]}}, ld_byte};
      2'b01:   load_ext = {{16{~is_unsigned & ld_half[15]}}, ld_half};
      default: load_ext = mem_rdata;
    endcase
  end

  // Sub-word store merge: replace only the addressed lanes.
  always_comb begin
    merged = mem_rdata;
    if (size == 2'b00) begin
      merged[{lane, 3'b000} +: 8] = wdata[7:0];
    end else if (lane[1]) begin
      merged[31:16] = wdata[15:0];
    end else begin
      merged[15:0] = wdata[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      lane        <= 2'b00;
      size        <= 2'b00;
      is_unsigned <= 1'b0;
      wdata       <= 32'h0;
      req_ready   <= 1'b1;
      done        <= 1'b0;
      err         <= 1'b0;
      rdata       <= 32'h0;
      mem_addr    <= '0;
      mem_wdata   <= 32'h0;
      mem_write   <= 1'b0;
      mem_read    <= 1'b0;
    end else begin
      // Pulses and strobes default low; each state re-asserts what it needs.
      done      <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            lane        <= req_addr[1:0];
            size        <= req_size;
            is_unsigned <= req_unsigned;
            wdata       <= req_wdata;
            req_ready   <= 1'b0;
            if (bad) begin
              // Suppressed access: straight to DONE, no strobe.
              state <= ST_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
              rdata <= 32'h0;
            end else begin
              err      <= 1'b0;
              mem_addr <= IDX_WIDTH'(req_addr[31:2]);
              if (!req_write) begin
                state    <= ST_RD;
                mem_read <= 1'b1;
              end else if (req_size[1]) begin
                state     <= ST_WR;
                mem_write <= 1'b1;
                mem_wdata <= req_wdata;
              end else begin
                state    <= ST_RMW_RD;
                mem_read <= 1'b1;
              end
            end
          end
        end
        ST_RD: begin
          rdata <= load_ext;
          done  <= 1'b1;
          state <= ST_DONE;
        end
        ST_RMW_RD: begin
          mem_wdata <= merged;
          mem_write <= 1'b1;
          state     <= ST_WR;
        end
        ST_WR: begin
          rdata <= 32'h0;
          done  <= 1'b1;
          state <= ST_DONE;
        end
        ST_DONE: begin
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a 64-word memory model is attached
// to the memory port, and every transaction is compared against a reference
// model (plain arithmetic on a shadow array) for latency, err, rdata, strobe
// counts, write address/data and final memory contents.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_rdata;

  logic [31:0] ram     [64];
  logic [31:0] ref_mem [64];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(
    .DEPTH_WORDS(64),
    .IDX_WIDTH  (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_wdata   (req_wdata),
    .done        (done),
    .rdata       (rdata),
    .err         (err),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_write   (mem_write),
    .mem_read    (mem_read),
    .mem_rdata   (mem_rdata)
  );

  assign mem_rdata = (mem_addr < 32'd64) ? ram[mem_addr[5:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_write && (mem_addr < 32'd64)) ram[mem_addr[5:0]] <= mem_wdata;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] wd);
    logic [31:0] idx;
    logic        bad;
    logic [31:0] w, v, mask, new_word;
    logic [31:0] exp_rdata;
    int          exp_lat, exp_wr, exp_rd, sh;
    int          wr_cnt, rd_cnt, both, got_lat, seen;
    logic [31:0] wr_a, wr_d;

    // Reference model.
    idx = {2'b00, addr[31:2]};
    bad = (idx >= 32'd64);
`ifdef MISALIGN_TRAP_EN
    if (sz == 2'd1 && addr[0]) bad = 1'b1;
    if (sz >= 2'd2 && addr[1:0] != 2'd0) bad = 1'b1;
`endif
    exp_rdata = 32'h0;
    new_word  = 32'h0;
    exp_wr    = 0;
    exp_rd    = 0;
    if (bad) begin
      exp_lat = 1;
    end else begin
      w = ref_mem[idx[5:0]];
      if (!wr) begin
        exp_lat = 2;
        exp_rd  = 1;
        if (sz == 2'd0) begin
          sh = 8 * int'(addr[1:0]);
          v  = (w >> sh) & 32'hFF;
          if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
          sh = addr[1] ? 16 : 0;
          v  = (w >> sh) & 32'hFFFF;
          if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
          v = w;
        end
        exp_rdata = v;
      end else begin
        exp_wr = 1;
        if (sz >= 2'd2) begin
          exp_lat  = 2;
          new_word = wd;
        end else begin
          exp_lat = 3;
          exp_rd  = 1;
          if (sz == 2'd0) begin
            sh   = 8 * int'(addr[1:0]);
            mask = 32'hFF << sh;
          end else begin
            sh   = addr[1] ? 16 : 0;
            mask = 32'hFFFF << sh;
          end
          new_word = (w & ~mask) | ((wd << sh) & mask);
        end
        ref_mem[idx[5:0]] = new_word;
      end
    end

    @(negedge clk);
    check_eq("ready_before", {31'b0, req_ready}, 32'd1);
    req_valid    = 1'b1;
    req_write    = wr;
    req_addr     = addr;
    req_size     = sz;
    req_unsigned = uns;
    req_wdata    = wd;
    @(posedge clk);
    #1;
    // Junk on the request bus while busy must be ignored.
    req_valid    = 1'($urandom);
    req_write    = 1'($urandom);
    req_addr     = $urandom;
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_wdata    = $urandom;

    wr_cnt = 0; rd_cnt = 0; both = 0; got_lat = 0; seen = 0;
    wr_a = 32'h0; wr_d = 32'h0;
    for (int lat = 1; lat <= 8; lat++) begin
      if (lat > 1) begin
        @(posedge clk);
        #1;
      end
      if (mem_read && mem_write) both++;
      if (mem_write) begin
        wr_cnt++;
        wr_a = mem_addr;
        wr_d = mem_wdata;
      end
      if (mem_read) rd_cnt++;
      if (done) begin
        got_lat = lat;
        seen    = 1;
        break;
      end
    end
    req_valid = 1'b0;

    check_eq("done_seen", 32'(seen), 32'd1);
    check_eq("latency", 32'(got_lat), 32'(exp_lat));
    check_eq("err", {31'b0, err}, {31'b0, bad});
    check_eq("rdata", rdata, exp_rdata);
    check_eq("write_count", 32'(wr_cnt), 32'(exp_wr));
    check_eq("read_count", 32'(rd_cnt), 32'(exp_rd));
    check_eq("strobes_overlap", 32'(both), 32'd0);
    if (exp_wr != 0) begin
      check_eq("write_addr", wr_a, idx);
      check_eq("write_data", wr_d, new_word);
    end

    @(posedge clk);
    #1;
    check_eq("ready_after", {31'b0, req_ready}, 32'd1);
    check_eq("done_pulse", {31'b0, done}, 32'd0);
    if (!bad) check_eq("mem_word", ram[idx[5:0]], ref_mem[idx[5:0]]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_addr     = 32'h0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_wdata    = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", {31'b0, req_ready}, 32'd1);
    check_eq("rst_done", {31'b0, done}, 32'd0);
    check_eq("rst_err", {31'b0, err}, 32'd0);
    check_eq("rst_mem_write", {31'b0, mem_write}, 32'd0);
    check_eq("rst_mem_read", {31'b0, mem_read}, 32'd0);
    check_eq("rst_rdata", rdata, 32'h0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_mem_wdata", mem_wdata, 32'h0);
    reset = 1'b0;

    // Fill memory through the unit so the bench owns every word's value.
    for (int i = 0; i < 64; i++) do_req(1'b1, 32'(i * 4), 2'd2, 1'b0, $urandom);

    // Word store then word load.
    do_req(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEAD_BEEF);
    do_req(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);

    // Byte store via read-modify-write.
    do_req(1'b1, 32'h0C, 2'd2, 1'b0, 32'h1122_3344);
    do_req(1'b1, 32'h0D, 2'd0, 1'b0, 32'h0000_00AA);

    // Extension cases.
    do_req(1'b1, 32'h14, 2'd2, 1'b0, 32'h80F0_007F);
    do_req(1'b0, 32'h14, 2'd0, 1'b0, 32'h0);
    do_req(1'b0, 32'h17, 2'd0, 1'b0, 32'h0);
    do_req(1'b0, 32'h16, 2'd1, 1'b1, 32'h0);
    do_req(1'b0, 32'h16, 2'd1, 1'b0, 32'h0);

    // Range errors: first out-of-range index, load and store.
    do_req(1'b0, 32'h100, 2'd2, 1'b0, 32'h0);
    do_req(1'b1, 32'h103, 2'd0, 1'b0, 32'h55);

    // Misaligned word load: trapped only when the option is built in.
    do_req(1'b0, 32'h06, 2'd2, 1'b0, 32'h0);

    // Reset during RMW_RD of a half store to word 2.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h0A;
    req_size  = 2'd1;
    req_wdata = 32'h0000_BEEF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check_eq("rmw_read_strobe", {31'b0, mem_read}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("midrst_ready", {31'b0, req_ready}, 32'd1);
    check_eq("midrst_done", {31'b0, done}, 32'd0);
    check_eq("midrst_mem_write", {31'b0, mem_write}, 32'd0);
    check_eq("midrst_mem_read", {31'b0, mem_read}, 32'd0);
    @(posedge clk);
    #1;
    check_eq("midrst_done2", {31'b0, done}, 32'd0);
    check_eq("midrst_mem_write2", {31'b0, mem_write}, 32'd0);
    check_eq("midrst_word2", ram[2], ref_mem[2]);

    // Randomized traffic, including out-of-range and misaligned addresses.
    for (int i = 0; i < 300; i++) begin
      do_req(1'($urandom), 32'($urandom_range(0, 64 * 4 + 31)), 2'($urandom),
             1'($urandom), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
